ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Display back-end of the seven-segment controller IP.
- Sits directly downstream of the AXI4-Lite register slave. It takes the value byte and control bits from slave registers 0/1 on a write strobe, and optionally converts binary to two BCD digits with a sequential converter.
- Time-multiplexes the two digits onto the shared Pmod SSD segment bus, with a ghosting dead time at each switch.

Parameters:
- CLK_FREQ_HZ, 100000000, ACLK frequency.
- REFRESH_HZ, 1000, digit toggle rate. DIV = CLK_FREQ_HZ/REFRESH_HZ must exceed DEAD_CYCLES+1 (elaboration assertion).
- DEAD_CYCLES, 100, blanked cycles after each digit switch.
- SEG_ACTIVE_LOW, 0, 1 inverts ssd_seg, including the blank pattern.

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- value_in  in  8  display value (slv_reg0[7:0]).
- ctrl_in  in  3  [0] enable, [1] decimal mode, [2] leading-zero blank (slv_reg1[2:0]).
- load  in  1  one-cycle strobe; capture value_in/ctrl_in.
- ssd_seg  out  7  segments, bit0=a … bit6=g, registered.
- ssd_sel  out  1  0 = ones/right digit, 1 = tens/left digit, registered.
- conv_busy  out  1  decimal conversion in progress.
- overflow  out  1  decimal-mode value >99; held until next load.
- cur_digits  out  8  {tens,ones} nibbles currently displayed, for readback.

Behaviour:
- Reset (async assert, sync-to-ACLK deassert not required):
  - ssd_seg = blank (7'h00, or 7'h7F if SEG_ACTIVE_LOW).
  - ssd_sel = 0, conv_busy = 0, overflow = 0, cur_digits = 0, ctrl = 0 (disabled), prescaler = 0, converter in IDLE.
- Load, hex mode (ctrl_in[1]=0):
  - ctrl and digits update at the edge where load=1: cur_digits = value_in, overflow = 0.
  - If a conversion is running, it is aborted and conv_busy drops the same edge.
- Load, decimal mode, converter FSM IDLE→SHIFT→DONE→IDLE:
  - Load edge: capture value, clear BCD scratch, conv_busy = 1.
  - SHIFT: 8 cycles of double-dabble (add 3 to any nibble ≥5, then shift left one bit). Scratch is 12-bit BCD plus 8-bit binary.
  - DONE (one cycle): cur_digits = BCD[7:0]; overflow = (BCD[11:8] != 0); conv_busy = 0.
  - conv_busy is high for exactly 9 cycles after the load edge.
  - cur_digits holds its old value throughout the conversion.
- load while conv_busy: restart from SHIFT with the new value (last write wins). busy stays high, and 9 cycles are counted from the new load.
- ctrl_in takes effect at the load edge regardless of mode.
- Scan:
  - Prescaler counts 0..DIV-1 while enable=1. At DIV-1 it wraps to 0 and ssd_sel toggles.
  - While the prescaler is < DEAD_CYCLES, the segment pattern is blank.
  - enable=0: prescaler held at 0, ssd_sel forced 0, seg blank. Re-enable starts at ones digit with the dead time.
- Segment pattern, registered one cycle after prescaler/sel/digit state:
  - Normal: hex decode of the selected nibble. 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
  - overflow=1: both digits show dash (7'h40).
  - ctrl[2]=1, tens=0, overflow=0: tens digit blank.
  - Priority: enable=0 / dead time > overflow dash > leading-zero blank > decode.
- ssd_sel and ssd_seg change on the same edge, so the dead time covers the digit switch.
- Reset mid-conversion or mid-scan: immediate return to reset values; no partial digits are latched.

Test Plan (CLK_FREQ_HZ=1000, REFRESH_HZ=100 → DIV=10, DEAD_CYCLES=2):
- Reset release, no load:
  - Required: ssd_seg=00 and ssd_sel=0 forever; conv_busy=0.
- Hex load value_in=8'h3A, ctrl=3'b001:
  - Required: cur_digits=3A next edge.
  - Scan: ssd_sel toggles every 10 cycles. After each toggle: 2 cycles seg=00, then ones shows 77 and tens shows 4F.
- Decimal load value_in=8'd57, ctrl=3'b011:
  - Required: conv_busy high exactly 9 cycles, then cur_digits=8'h57, overflow=0.
  - Old digits displayed until completion; then tens shows 6D and ones shows 07.
- Decimal value 8'd200:
  - Required: overflow=1, both digits 40.
  - Then hex load of 8'h05 with ctrl=3'b101: overflow=0, tens blank, ones shows 6D.
- Decimal load of 8'd99, then load of 8'd7 at busy cycle 4:
  - Required: busy stays high 9 cycles after the second load; final cur_digits=8'h07.
  - ctrl[2]=1 blanks the tens digit.
- ARESET pulse mid-conversion and mid-scan; repeat with SEG_ACTIVE_LOW=1:
  - Required: outputs return to reset values asynchronously (blank = 7F when active-low). Also check 8 displays as 00.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Seven-segment back end: captures value/control on load, optionally converts binary to BCD,
// and time-multiplexes two digits onto a shared segment bus with a blanking dead time.
module ssd_scan_driver #(
    parameter int unsigned CLK_FREQ_HZ    = 100000000,
    parameter int unsigned REFRESH_HZ     = 1000,
    parameter int unsigned DEAD_CYCLES    = 100,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [7:0] value_in,
    input  logic [2:0] ctrl_in,
    input  logic       load,
    output logic [6:0] ssd_seg,
    output logic       ssd_sel,
    output logic       conv_busy,
    output logic       overflow,
    output logic [7:0] cur_digits
);
    localparam int unsigned   DIV       = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_DEAD  = PW'(DEAD_CYCLES);
    localparam logic [6:0]    SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    if (DIV <= DEAD_CYCLES + 1) begin : g_bad_div
        $error("ssd_scan_driver: DIV must exceed DEAD_CYCLES+1");
    end

    // Converter states: IDLE waiting | SHIFT 8 double-dabble steps | DONE publish digits
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_e;

    conv_state_e   state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [11:0]   bcd_q, bcd_d, bcd_adj;
    logic [7:0]    bin_q, bin_d;
    logic [7:0]    digits_q, digits_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          unused_bcd_msb;

    logic [PW-1:0] pre_q;
    logic          sel_q, sel_out_q;
    logic [6:0]    seg_q, seg_d, pat;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ctrl_in[1] ? S_SHIFT : S_IDLE;
        end else begin
            case (state_q)
                S_SHIFT: if (bit_cnt_q == 3'd7) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bcd_adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? bcd_q[k*4 +: 4] + 4'd3 : bcd_q[k*4 +: 4];
        end
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        bit_cnt_d = bit_cnt_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        ctrl_d    = ctrl_q;
        if (load) begin
            ctrl_d    = ctrl_in;
            bit_cnt_d = 3'd0;
            if (ctrl_in[1]) begin
                bin_d = value_in;
                bcd_d = 12'h000;
            end else begin
                digits_d = value_in;
                ovf_d    = 1'b0;
            end
        end else begin
            case (state_q)
                S_SHIFT: begin
                    bcd_d     = {bcd_adj[10:0], bin_q[7]};
                    bin_d     = {bin_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                S_DONE: begin
                    digits_d = bcd_q[7:0];
                    ovf_d    = |bcd_q[11:8];
                end
                default: ;
            endcase
        end
    end

    // Hundreds nibble never reaches 5 for an 8-bit input, so its carry-out is dropped.
    assign unused_bcd_msb = bcd_adj[11];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bcd_q     <= '0;
            bin_q     <= '0;
            bit_cnt_q <= '0;
            digits_q  <= '0;
            ovf_q     <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            bit_cnt_q <= bit_cnt_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_comb begin
        nib = sel_q ? digits_q[7:4] : digits_q[3:0];
        if (!ctrl_q[0] || (pre_q < PRE_DEAD))                pat = 7'h00;
        else if (ovf_q)                                     pat = 7'h40;
        else if (ctrl_q[2] && sel_q && digits_q[7:4] == 4'h0) pat = 7'h00;
        else                                                pat = hex7(nib);
        seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
    end

    // Select is delayed alongside the segment register so both switch on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pre_q     <= '0;
            sel_q     <= 1'b0;
            sel_out_q <= 1'b0;
            seg_q     <= SEG_BLANK;
        end else begin
            seg_q     <= seg_d;
            sel_out_q <= sel_q;
            if (!ctrl_q[0]) begin
                pre_q <= '0;
                sel_q <= 1'b0;
            end else if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                sel_q <= ~sel_q;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    assign ssd_seg    = seg_q;
    assign ssd_sel    = sel_out_q;
    assign conv_busy  = (state_q != S_IDLE);
    assign overflow   = ovf_q;
    assign cur_digits = digits_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: two instances (active-high and active-low segments) driven in
// lockstep and compared every cycle against an arithmetic reference model.
module tb_ssd_scan_driver;
    localparam int DIV  = 10;
    localparam int DEAD = 2;

    logic       ACLK, ARESET, load;
    logic [7:0] value_in;
    logic [2:0] ctrl_in;
    logic [6:0] seg_h, seg_l;
    logic       sel_h, sel_l, busy_h, busy_l, ovf_h, ovf_l;
    logic [7:0] dig_h, dig_l;

    int tests = 0;
    int fails = 0;

    ssd_scan_driver #(.CLK_FREQ_HZ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .ACLK(ACLK), .ARESET(ARESET), .value_in(value_in), .ctrl_in(ctrl_in), .load(load),
        .ssd_seg(seg_h), .ssd_sel(sel_h), .conv_busy(busy_h), .overflow(ovf_h), .cur_digits(dig_h));

    ssd_scan_driver #(.CLK_FREQ_HZ(1000), .REFRESH_HZ(100), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .ACLK(ACLK), .ARESET(ARESET), .value_in(value_in), .ctrl_in(ctrl_in), .load(load),
        .ssd_seg(seg_l), .ssd_sel(sel_l), .conv_busy(busy_l), .overflow(ovf_l), .cur_digits(dig_l));

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: age = enabled cycles since scan start; busy = conversion cycles left.
    int         m_age, m_busy;
    logic [2:0] m_ctrl;
    logic [7:0] m_dig, m_pend;
    logic       m_ovf;
    logic [6:0] e_seg;
    logic       e_sel;

    function automatic logic [6:0] ref_pat(input logic [2:0] c, input int age,
                                           input logic [7:0] dg, input logic ov);
        int   pre;
        logic s;
        pre = age % DIV;
        s   = ((age / DIV) % 2) == 1;
        if (!c[0] || pre < DEAD) return 7'h00;
        if (ov) return 7'h40;
        if (c[2] && s && dg[7:4] == 4'h0) return 7'h00;
        return seg_tbl[s ? dg[7:4] : dg[3:0]];
    endfunction

    task automatic model_reset();
        m_age = 0; m_busy = 0; m_ctrl = 3'b000; m_dig = 8'h00; m_pend = 8'h00; m_ovf = 1'b0;
        e_seg = 7'h00; e_sel = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] v, input logic [2:0] c);
        int pv;
        e_seg = ref_pat(m_ctrl, m_age, m_dig, m_ovf);
        e_sel = ((m_age / DIV) % 2) == 1;
        m_age = m_ctrl[0] ? m_age + 1 : 0;
        if (ld) begin
            m_ctrl = c;
            if (c[1]) begin
                m_busy = 9; m_pend = v;
            end else begin
                m_dig = v; m_ovf = 1'b0; m_busy = 0;
            end
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
                pv    = int'(m_pend);
                m_dig = {4'((pv % 100) / 10), 4'(pv % 10)};
                m_ovf = pv > 99;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("seg",       {1'b0, seg_h}, {1'b0, e_seg});
        check("seg_al",    {1'b0, seg_l}, {1'b0, ~e_seg});
        check("sel",       {7'b0, sel_h}, {7'b0, e_sel});
        check("sel_al",    {7'b0, sel_l}, {7'b0, e_sel});
        check("busy",      {7'b0, busy_h}, {7'b0, (m_busy > 0)});
        check("busy_al",   {7'b0, busy_l}, {7'b0, (m_busy > 0)});
        check("overflow",  {7'b0, ovf_h}, {7'b0, m_ovf});
        check("digits",    dig_h, m_dig);
        check("digits_al", dig_l, m_dig);
    endtask

    // One clock: inputs driven after the falling edge, outputs checked at the next falling edge.
    task automatic cyc(input logic ld, input logic [7:0] v, input logic [2:0] c);
        load = ld; value_in = v; ctrl_in = c;
        @(posedge ACLK);
        model_edge(ld, v, c);
        @(negedge ACLK);
        load = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, value_in, ctrl_in);
    endtask

    task automatic pulse_reset();
        #2 ARESET = 1'b1;
        #1;
        check("rst_seg",    {1'b0, seg_h}, 8'h00);
        check("rst_seg_al", {1'b0, seg_l}, 8'h7F);
        check("rst_sel",    {7'b0, sel_h}, 8'h00);
        check("rst_busy",   {7'b0, busy_h}, 8'h00);
        check("rst_ovf",    {7'b0, ovf_h}, 8'h00);
        check("rst_digits", dig_h, 8'h00);
        model_reset();
        @(negedge ACLK);
        ARESET = 1'b0;
        check_all();
    endtask

    initial begin
        ARESET = 1'b1; load = 1'b0; value_in = 8'h00; ctrl_in = 3'b000;
        model_reset();
        repeat (2) @(negedge ACLK);
        check_all();
        ARESET = 1'b0;

        idle(25);

        // Hex 3A: ones 'A' then tens '3' after the two-cycle dead time.
        cyc(1'b1, 8'h3A, 3'b001);
        check("hex_digits", dig_h, 8'h3A);
        idle(2);
        check("hex_dead0", {1'b0, seg_h}, 8'h00);
        idle(1);
        check("hex_ones", {1'b0, seg_h}, 8'h77);
        check("hex_sel0", {7'b0, sel_h}, 8'h00);
        idle(7);
        check("hex_ones_last", {1'b0, seg_h}, 8'h77);
        idle(1);
        check("hex_sel1", {7'b0, sel_h}, 8'h01);
        check("hex_dead1", {1'b0, seg_h}, 8'h00);
        idle(2);
        check("hex_tens", {1'b0, seg_h}, 8'h4F);

        // Decimal 57: busy exactly 9 cycles, old digits held meanwhile.
        cyc(1'b1, 8'd57, 3'b011);
        check("dec_busy_first", {7'b0, busy_h}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 3'b011);
            check("dec_busy_hold", {7'b0, busy_h}, 8'h01);
            check("dec_old_digits", dig_h, 8'h3A);
        end
        cyc(1'b0, 8'h00, 3'b011);
        check("dec_busy_end", {7'b0, busy_h}, 8'h00);
        check("dec_digits", dig_h, 8'h57);
        check("dec_ovf", {7'b0, ovf_h}, 8'h00);
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 8'h00, 3'b011);
            if (seg_h != 7'h00) check("dec_disp", {1'b0, seg_h}, sel_h ? 8'h6D : 8'h07);
        end

        // Decimal 200 overflows and shows dashes; hex 05 with leading-zero blank clears it.
        cyc(1'b1, 8'd200, 3'b011);
        idle(9);
        check("ovf_set", {7'b0, ovf_h}, 8'h01);
        check("ovf_digits", dig_h, 8'h00);
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 8'h00, 3'b011);
            if (seg_h != 7'h00) check("ovf_dash", {1'b0, seg_h}, 8'h40);
        end
        cyc(1'b1, 8'h05, 3'b101);
        check("ovf_clear", {7'b0, ovf_h}, 8'h00);
        check("lz_digits", dig_h, 8'h05);
        idle(25);

        // Decimal 99 restarted by 7 at busy cycle 4.
        cyc(1'b1, 8'd99, 3'b111);
        idle(3);
        cyc(1'b1, 8'd7, 3'b111);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 3'b111);
            check("restart_busy", {7'b0, busy_h}, 8'h01);
        end
        cyc(1'b0, 8'h00, 3'b111);
        check("restart_done", {7'b0, busy_h}, 8'h00);
        check("restart_digits", dig_h, 8'h07);
        idle(25);

        // Reset mid-conversion.
        cyc(1'b1, 8'd123, 3'b011);
        idle(3);
        pulse_reset();
        idle(5);

        // Digit 8 on the active-low instance, then reset mid-scan.
        cyc(1'b1, 8'h88, 3'b001);
        idle(3);
        check("eight_ah", {1'b0, seg_h}, 8'h7F);
        check("eight_al", {1'b0, seg_l}, 8'h00);
        idle(12);
        pulse_reset();

        // Enable off mid-scan, then back on.
        cyc(1'b1, 8'h42, 3'b001);
        idle(14);
        cyc(1'b1, 8'h42, 3'b000);
        idle(5);
        check("dis_seg", {1'b0, seg_h}, 8'h00);
        check("dis_sel", {7'b0, sel_h}, 8'h00);
        cyc(1'b1, 8'h42, 3'b001);
        idle(12);

        // Randomized loads, including loads during conversions.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                cyc(1'b1, 8'($urandom_range(0, 255)),
                    {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0)});
            end else begin
                cyc(1'b0, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            end
            if (i == 200) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
